// File: rtl/ym_reg_sequencer_pkg.sv
// Shared types and constants for the jt12 register-write sequencer:
// FSM state encoding, table entry layout and OPN register addresses.
package ym_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_LATCH = 4'd2,
    S_POLL  = 4'd3,
    S_WADDR = 4'd4,
    S_RELA  = 4'd5,
    S_WDATA = 4'd6,
    S_RELD  = 4'd7,
    S_GAP   = 4'd8,
    S_FIN   = 4'd9
  } seq_state_e;

  // Table entry layout: {last, a1, reg[7:0], val[7:0]}
  localparam int ENT_LAST   = 17;
  localparam int ENT_A1     = 16;
  localparam int ENT_REG_HI = 15;
  localparam int ENT_REG_LO = 8;
  localparam int ENT_VAL_HI = 7;
  localparam int ENT_VAL_LO = 0;

  // Register addresses of the FM core
  localparam logic [7:0] REG_DTMUL    = 8'h30;
  localparam logic [7:0] REG_TL       = 8'h40;
  localparam logic [7:0] REG_KSAR     = 8'h50;
  localparam logic [7:0] REG_DR       = 8'h60;
  localparam logic [7:0] REG_SR       = 8'h70;
  localparam logic [7:0] REG_SLRR     = 8'h80;
  localparam logic [7:0] REG_SSGEG    = 8'h90;
  localparam logic [7:0] REG_FNUM_LO  = 8'hA0;
  localparam logic [7:0] REG_FNUM_HI  = 8'hA4;
  localparam logic [7:0] REG_FBCN     = 8'hB0;
  localparam logic [7:0] REG_KON      = 8'h28;
  localparam logic [7:0] REG_PRESCALE = 8'h27;
  localparam logic [7:0] REG_SSG_MIX  = 8'h07;

  // Pack one table entry
  function automatic logic [17:0] make_entry(input logic last, input logic a1,
                                             input logic [7:0] r, input logic [7:0] v);
    return {last, a1, r, v};
  endfunction

endpackage

// File: rtl/ym_reg_sequencer_if.sv
// Chip bus between the sequencer (master) and the jt12 core (slave).
interface ym_reg_sequencer_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output wr_n, output addr, output din, input dout);
  modport slave  (input cs_n, input wr_n, input addr, input din, output dout);
endinterface

// File: rtl/ym_reg_sequencer_init_rom.sv
// Default initialisation table for the FM core. Synchronous read: data
// follows the address by one clock, independent of the chip clock enable.
module ym_init_rom
  import ym_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [17:0]              data
);

  logic [17:0] data_r;

  // Table contents; unused rows read as zero
  function automatic logic [17:0] rom_word(input logic [7:0] idx);
    logic [17:0] w;
    case (idx)
      8'd0:    w = make_entry(1'b0, 1'b0, REG_PRESCALE, 8'h3B);
      8'd1:    w = make_entry(1'b0, 1'b0, REG_SSG_MIX,  8'h38);
      8'd2:    w = make_entry(1'b0, 1'b0, REG_FBCN,     8'h07);
      8'd3:    w = make_entry(1'b0, 1'b0, REG_DTMUL,    8'h01);
      8'd4:    w = make_entry(1'b0, 1'b0, REG_TL,       8'h00);
      8'd5:    w = make_entry(1'b0, 1'b0, REG_KSAR,     8'h1F);
      8'd6:    w = make_entry(1'b0, 1'b0, REG_DR,       8'h00);
      8'd7:    w = make_entry(1'b0, 1'b0, REG_SR,       8'h00);
      8'd8:    w = make_entry(1'b0, 1'b0, REG_SLRR,     8'h00);
      8'd9:    w = make_entry(1'b0, 1'b0, REG_SSGEG,    8'h00);
      8'd10:   w = make_entry(1'b0, 1'b0, REG_FNUM_HI,  8'h24);
      8'd11:   w = make_entry(1'b0, 1'b0, REG_FNUM_LO,  8'h0F);
      8'd12:   w = make_entry(1'b1, 1'b0, REG_KON,      8'h10);
      default: w = 18'd0;
    endcase
    return w;
  endfunction

  // Registered table read
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      data_r <= 18'd0;
    end else begin
      data_r <= rom_word(8'(addr));
    end
  end

  assign data = data_r;

endmodule

// File: rtl/ym_reg_sequencer.sv
// Table-driven register-write sequencer for the jt12 bus. Walks the table
// from entry 0 on start, issuing an address-phase / data-phase write pair
// per entry, optionally waiting for busy to clear, with an idle gap between
// entries. All bus and status outputs are registers updated on cen cycles;
// each state drives its own bus levels, so a strobe appears one cen-cycle
// after the state that produces it is entered.
module ym_reg_sequencer
  import ym_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SETUP    = 1,
  parameter int GAP      = 32,
  parameter int USE_BUSY = 1,
  parameter int TIMEOUT  = 255,
  parameter int USE_ROM  = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic                     start,
  output logic [$clog2(DEPTH)-1:0] tbl_addr,
  input  logic [17:0]              tbl_data,
  ym_reg_sequencer_if.master       bus,
  output logic                     running,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   wr_count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [3:0]      SETUP_LAST = 4'(SETUP - 1);
  localparam logic [15:0]     GAP_LAST   = 16'(GAP - 1);
  localparam bit              GAP_ZERO   = (GAP == 0);
  localparam logic [15:0]     POLL_LAST  = 16'(TIMEOUT - 1);
  localparam logic [AW-1:0]   ADDR_LAST  = AW'(DEPTH - 1);
  localparam bit              BUSY_EN    = (USE_BUSY != 0);
  localparam logic [AW:0]     CNT_ONE    = (AW + 1)'(1);

  seq_state_e     state_r;
  logic [17:0]    entry_r;
  logic [3:0]     setup_cnt_r;
  logic [15:0]    gap_cnt_r;
  logic [15:0]    poll_cnt_r;
  logic           cs_n_r;
  logic           wr_n_r;
  logic [1:0]     addr_r;
  logic [7:0]     din_r;
  logic [AW-1:0]  tbl_addr_r;
  logic           running_r;
  logic           done_r;
  logic           err_r;
  logic [AW:0]    wr_count_r;

  logic [17:0]    rom_data_s;
  logic [17:0]    tbl_sel_s;
  logic           unused_dout_s;

  ym_init_rom #(.DEPTH(DEPTH)) u_rom (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .addr   (tbl_addr_r),
    .data   (rom_data_s)
  );

  // Entries come from the built-in ROM or from an external table
  assign tbl_sel_s     = (USE_ROM != 0) ? rom_data_s : tbl_data;
  assign unused_dout_s = ^bus.dout[6:0];

  // Sequencer FSM with counters and registered bus/status outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      entry_r     <= 18'd0;
      setup_cnt_r <= 4'd0;
      gap_cnt_r   <= 16'd0;
      poll_cnt_r  <= 16'd0;
      cs_n_r      <= 1'b1;
      wr_n_r      <= 1'b1;
      addr_r      <= 2'd0;
      din_r       <= 8'd0;
      tbl_addr_r  <= '0;
      running_r   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wr_count_r  <= '0;
    end else if (cen) begin
      case (state_r)
        S_IDLE: begin
          cs_n_r <= 1'b1;
          wr_n_r <= 1'b1;
          if (start) begin
            tbl_addr_r <= '0;
            wr_count_r <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            running_r  <= 1'b1;
            state_r    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_r <= S_LATCH;
        end
        S_LATCH: begin
          entry_r     <= tbl_sel_s;
          setup_cnt_r <= 4'd0;
          poll_cnt_r  <= 16'd0;
          state_r     <= BUSY_EN ? S_POLL : S_WADDR;
        end
        S_POLL: begin
          cs_n_r <= 1'b0;
          wr_n_r <= 1'b1;
          addr_r <= {entry_r[ENT_A1], 1'b0};
          if (!bus.dout[7]) begin
            state_r <= S_WADDR;
          end else if (poll_cnt_r == POLL_LAST) begin
            err_r   <= 1'b1;
            state_r <= S_FIN;
          end else begin
            poll_cnt_r <= poll_cnt_r + 16'd1;
          end
        end
        S_WADDR: begin
          cs_n_r <= 1'b0;
          wr_n_r <= 1'b0;
          addr_r <= {entry_r[ENT_A1], 1'b0};
          din_r  <= entry_r[ENT_REG_HI:ENT_REG_LO];
          if (setup_cnt_r == SETUP_LAST) begin
            setup_cnt_r <= 4'd0;
            state_r     <= S_RELA;
          end else begin
            setup_cnt_r <= setup_cnt_r + 4'd1;
          end
        end
        S_RELA: begin
          wr_n_r  <= 1'b1;
          state_r <= S_WDATA;
        end
        S_WDATA: begin
          wr_n_r <= 1'b0;
          addr_r <= {entry_r[ENT_A1], 1'b1};
          din_r  <= entry_r[ENT_VAL_HI:ENT_VAL_LO];
          if (setup_cnt_r == SETUP_LAST) begin
            setup_cnt_r <= 4'd0;
            state_r     <= S_RELD;
          end else begin
            setup_cnt_r <= setup_cnt_r + 4'd1;
          end
        end
        S_RELD: begin
          wr_n_r     <= 1'b1;
          addr_r[0]  <= 1'b0;
          wr_count_r <= wr_count_r + CNT_ONE;
          gap_cnt_r  <= 16'd0;
          // The last row ends the walk even without its last bit: no wrap
          if (entry_r[ENT_LAST] || (tbl_addr_r == ADDR_LAST)) begin
            state_r <= S_FIN;
          end else begin
            state_r <= S_GAP;
          end
        end
        S_GAP: begin
          cs_n_r <= 1'b1;
          if (GAP_ZERO || (gap_cnt_r == GAP_LAST)) begin
            tbl_addr_r <= tbl_addr_r + AW'(1);
            state_r    <= S_FETCH;
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end
        S_FIN: begin
          cs_n_r    <= 1'b1;
          wr_n_r    <= 1'b1;
          running_r <= 1'b0;
          done_r    <= 1'b1;
          state_r   <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cs_n = cs_n_r;
  assign bus.wr_n = wr_n_r;
  assign bus.addr = addr_r;
  assign bus.din  = din_r;
  assign tbl_addr = tbl_addr_r;
  assign running  = running_r;
  assign done     = done_r;
  assign err      = err_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_ym_reg_sequencer.sv
// Directed bench for ym_reg_sequencer. Three instances: A (built-in ROM, no
// busy polling, GAP=4), B (built-in ROM, busy polling), C (external 4-row
// table without last bits). Expected bus writes are queued when a sequence
// is started and compared as each wr_n falling edge is observed.
module tb_ym_reg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cen_a, cen_b, cen_c, start_a, start_b, start_c;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   cen_div = 1'b0;

  ym_reg_sequencer_if bus_a ();
  ym_reg_sequencer_if bus_b ();
  ym_reg_sequencer_if bus_c ();

  logic [3:0]  tbl_addr_a, tbl_addr_b;
  logic [1:0]  tbl_addr_c;
  logic [4:0]  wr_count_a, wr_count_b;
  logic [2:0]  wr_count_c;
  logic        running_a, running_b, running_c;
  logic        done_a, done_b, done_c;
  logic        err_a, err_b, err_c;
  logic [17:0] tbl_data_c;
  logic [17:0] tab_c [4];

  // {reg, val} pairs of the default init table, in order
  logic [15:0] rom_model [13] = '{16'h273B, 16'h0738, 16'hB007, 16'h3001, 16'h4000,
                                  16'h501F, 16'h6000, 16'h7000, 16'h8000, 16'h9000,
                                  16'hA424, 16'hA00F, 16'h2810};

  typedef logic [9:0] wr_t;   // {addr[1:0], din[7:0]}
  wr_t qa[$];
  wr_t qb[$];
  wr_t qc[$];

  logic       prev_wr_a = 1'b1, prev_wr_b = 1'b1, prev_wr_c = 1'b1;
  logic [1:0] prev_addr_a = 2'd0;
  logic [7:0] prev_din_a = 8'd0;
  int         low_len_a = 0, exp_low_a = 1;
  int         wcnt_a = 0, wcnt_b = 0;

  ym_reg_sequencer #(.DEPTH(16), .SETUP(1), .GAP(4), .USE_BUSY(0), .TIMEOUT(255), .USE_ROM(1)) u_a (
    .clk_in(clk), .rst_n(rst_n), .cen(cen_a), .start(start_a), .tbl_addr(tbl_addr_a),
    .tbl_data(18'd0), .bus(bus_a), .running(running_a), .done(done_a), .err(err_a),
    .wr_count(wr_count_a));

  ym_reg_sequencer #(.DEPTH(16), .SETUP(1), .GAP(4), .USE_BUSY(1), .TIMEOUT(255), .USE_ROM(1)) u_b (
    .clk_in(clk), .rst_n(rst_n), .cen(cen_b), .start(start_b), .tbl_addr(tbl_addr_b),
    .tbl_data(18'd0), .bus(bus_b), .running(running_b), .done(done_b), .err(err_b),
    .wr_count(wr_count_b));

  ym_reg_sequencer #(.DEPTH(4), .SETUP(1), .GAP(2), .USE_BUSY(0), .TIMEOUT(255), .USE_ROM(0)) u_c (
    .clk_in(clk), .rst_n(rst_n), .cen(cen_c), .start(start_c), .tbl_addr(tbl_addr_c),
    .tbl_data(tbl_data_c), .bus(bus_c), .running(running_c), .done(done_c), .err(err_c),
    .wr_count(wr_count_c));

  // External table for instance C: synchronous read, one clock latency
  always @(posedge clk) tbl_data_c <= tab_c[tbl_addr_c];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_a();
    wr_t e;
    if (prev_wr_a && !bus_a.wr_n) begin
      wcnt_a++;
      if (qa.size() == 0) check("A extra write", {22'd0, bus_a.addr, bus_a.din}, 32'hFFFF_FFFF);
      else begin
        e = qa.pop_front();
        check("A write", {22'd0, bus_a.addr, bus_a.din}, {22'd0, e});
      end
    end
    if (!prev_wr_a && !bus_a.wr_n) begin
      check("A addr held", {30'd0, bus_a.addr}, {30'd0, prev_addr_a});
      check("A din held", {24'd0, bus_a.din}, {24'd0, prev_din_a});
    end
    if (!prev_wr_a && bus_a.wr_n) check("A strobe len", low_len_a, exp_low_a);
    low_len_a   = bus_a.wr_n ? 0 : low_len_a + 1;
    prev_wr_a   = bus_a.wr_n;
    prev_addr_a = bus_a.addr;
    prev_din_a  = bus_a.din;
  endtask

  task automatic mon_b();
    wr_t e;
    if (prev_wr_b && !bus_b.wr_n) begin
      wcnt_b++;
      if (qb.size() == 0) check("B extra write", {22'd0, bus_b.addr, bus_b.din}, 32'hFFFF_FFFF);
      else begin
        e = qb.pop_front();
        check("B write", {22'd0, bus_b.addr, bus_b.din}, {22'd0, e});
      end
    end
    prev_wr_b = bus_b.wr_n;
  endtask

  task automatic mon_c();
    wr_t e;
    if (prev_wr_c && !bus_c.wr_n) begin
      if (qc.size() == 0) check("C extra write", {22'd0, bus_c.addr, bus_c.din}, 32'hFFFF_FFFF);
      else begin
        e = qc.pop_front();
        check("C write", {22'd0, bus_c.addr, bus_c.din}, {22'd0, e});
      end
    end
    prev_wr_c = bus_c.wr_n;
  endtask

  // One clock: sample 1 ns after the edge, monitor, then set next cen for A
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon_a();
    mon_b();
    mon_c();
    cen_a = cen_div ? ((cyc % 3) == 0) : 1'b1;
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : ((w == 1) ? done_b : done_c);
  endfunction

  task automatic wait_done(input int w, input int limit, output int k);
    k = 0;
    while (!done_of(w) && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic push_rom(input int w);
    for (int i = 0; i < 13; i++) begin
      if (w == 0) begin
        qa.push_back({2'b00, rom_model[i][15:8]});
        qa.push_back({2'b01, rom_model[i][7:0]});
      end else begin
        qb.push_back({2'b00, rom_model[i][15:8]});
        qb.push_back({2'b01, rom_model[i][7:0]});
      end
    end
  endtask

  task automatic push_c();
    for (int i = 0; i < 4; i++) begin
      qc.push_back({tab_c[i][16], 1'b0, tab_c[i][15:8]});
      qc.push_back({tab_c[i][16], 1'b1, tab_c[i][7:0]});
    end
  endtask

  initial begin
    int k, first_low, done_k, w0;
    tab_c[0] = {1'b0, 1'b1, 8'h30, 8'h11};
    tab_c[1] = {1'b0, 1'b0, 8'h40, 8'h22};
    tab_c[2] = {1'b0, 1'b1, 8'hA0, 8'h33};
    tab_c[3] = {1'b0, 1'b0, 8'h28, 8'hF0};
    rst_n = 1'b0; cen_a = 1'b1; cen_b = 1'b1; cen_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bus_a.dout = 8'h00; bus_b.dout = 8'h00; bus_c.dout = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst bus", {20'd0, bus_a.cs_n, bus_a.wr_n, bus_a.addr, bus_a.din}, {20'd0, 1'b1, 1'b1, 2'b00, 8'h00});
    check("rst status", {28'd0, running_a, done_a, err_a, 1'b0}, 32'd0);
    check("rst counters", {23'd0, tbl_addr_a, wr_count_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full default ROM, cen=1, with an ignored start while running
    push_rom(0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 0; first_low = -1; done_k = -1;
    while (k < 300 && done_k < 0) begin
      tick();
      k++;
      if (first_low < 0 && !bus_a.wr_n) first_low = k;
      if (done_a) done_k = k;
      start_a = (k == 50);
    end
    start_a = 1'b0;
    check("A first strobe edge", first_low, 3);
    check("A done edge", done_k, 127);          // 12*(6+4) + 6 + 1
    check("A wr_count", {27'd0, wr_count_a}, 32'd13);
    check("A writes pending", qa.size(), 0);
    check("A end status", {29'd0, running_a, err_a, bus_a.cs_n}, {29'd0, 1'b0, 1'b0, 1'b1});

    // cen 1-of-3: same bus sequence, strobes three clocks long
    push_rom(0);
    cen_div = 1'b1; exp_low_a = 3;
    start_a = 1'b1;
    k = 0;
    while (!running_a && k < 12) begin
      tick();
      k++;
    end
    start_a = 1'b0;
    wait_done(0, 1200, k);
    check("A cen3 done", {31'd0, done_a}, 32'd1);
    check("A cen3 wr_count", {27'd0, wr_count_a}, 32'd13);
    check("A cen3 writes pending", qa.size(), 0);
    cen_div = 1'b0; exp_low_a = 1;
    tick();
    tick();

    // Reset during the data phase of entry 5, start on the same edge
    push_rom(0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    w0 = wcnt_a;
    k = 0;
    while (wcnt_a < w0 + 12 && k < 200) begin
      tick();
      k++;
    end
    check("A entry5 data phase", {22'd0, bus_a.wr_n, bus_a.addr, bus_a.din}, {22'd0, 1'b0, 2'b01, 8'h1F});
    rst_n = 1'b0;
    start_a = 1'b1;
    tick();
    check("A reset bus", {28'd0, bus_a.cs_n, bus_a.wr_n, 2'b00}, {28'd0, 1'b1, 1'b1, 2'b00});
    check("A reset wr_count", {27'd0, wr_count_a}, 32'd0);
    check("A reset beats start", {31'd0, running_a}, 32'd0);
    qa.delete();
    rst_n = 1'b1;
    start_a = 1'b0;
    tick();
    push_rom(0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 300, k);
    check("A replay wr_count", {27'd0, wr_count_a}, 32'd13);
    check("A replay writes pending", qa.size(), 0);

    // Busy held for 20 clocks, then released
    bus_b.dout = 8'h80;
    push_rom(1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (20) tick();
    check("B polling", {29'd0, bus_b.cs_n, bus_b.wr_n, err_b}, {29'd0, 1'b0, 1'b1, 1'b0});
    bus_b.dout = 8'h00;
    tick();   // this edge sees busy clear and enters WADDR
    check("B no strobe yet", {31'd0, bus_b.wr_n}, 32'd1);
    tick();   // WADDR drives the strobe
    check("B first strobe", {21'd0, bus_b.wr_n, bus_b.addr, bus_b.din}, {21'd0, 1'b0, 2'b00, 8'h27});
    wait_done(1, 400, k);
    check("B busy run", {26'd0, err_b, wr_count_b}, {26'd0, 1'b0, 5'd13});
    check("B writes pending", qb.size(), 0);

    // Busy stuck: abort after TIMEOUT polls with no write
    bus_b.dout = 8'h80;
    w0 = wcnt_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1, 400, k);
    check("B timeout edge", k, 258);              // 3 + 255 polls, then FIN
    check("B timeout status", {25'd0, done_b, err_b, wr_count_b}, {25'd0, 1'b1, 1'b1, 5'd0});
    check("B strobes on timeout", wcnt_b - w0, 0);
    check("B timeout cs_n", {31'd0, bus_b.cs_n}, 32'd1);
    bus_b.dout = 8'h00;

    // DEPTH=4 table with no last bit: stops on the final row, twice
    for (int r = 0; r < 2; r++) begin
      push_c();
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      wait_done(2, 200, k);
      check("C done", {31'd0, done_c}, 32'd1);
      check("C wr_count", {29'd0, wr_count_c}, 32'd4);
      check("C tbl_addr", {30'd0, tbl_addr_c}, 32'd3);
      check("C writes pending", qc.size(), 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
